// File: rtl/bf_sequencer.sv
// bf_sequencer: fetch/decode/execute sequencer for the BF machine core.
// Drives program/data RAM addresses straight from pc/dp, scans for matching
// brackets one byte per two cycles, and handshakes '.' and ',' with board I/O.
module bf_sequencer #(
  parameter int PC_W = 8,
  parameter int DP_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            go,
  output logic [PC_W-1:0] pm_addr,
  input  logic [7:0]      pm_rdata,
  output logic [DP_W-1:0] dm_addr,
  input  logic [7:0]      dm_rdata,
  output logic [7:0]      dm_wdata,
  output logic            dm_we,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_req,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] pc,
  output logic [DP_W-1:0] dp,
  output logic [3:0]      state,
  output logic            halted,
  output logic            error
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_OUT_WAIT = 4'd3,
    S_IN_WAIT  = 4'd4,
    S_SF_FETCH = 4'd5,
    S_SF_CHECK = 4'd6,
    S_SB_FETCH = 4'd7,
    S_SB_CHECK = 4'd8,
    S_HALT     = 4'd9,
    S_ERROR    = 4'd10
  } state_t;

  localparam logic [7:0] OP_INC  = 8'h2B;  // +
  localparam logic [7:0] OP_DEC  = 8'h2D;  // -
  localparam logic [7:0] OP_RGT  = 8'h3E;  // >
  localparam logic [7:0] OP_LFT  = 8'h3C;  // <
  localparam logic [7:0] OP_OUT  = 8'h2E;  // .
  localparam logic [7:0] OP_IN   = 8'h2C;  // ,
  localparam logic [7:0] OP_OPEN = 8'h5B;  // [
  localparam logic [7:0] OP_CLS  = 8'h5D;  // ]
  localparam logic [7:0] OP_END  = 8'h00;

  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
  localparam logic [PC_W-1:0] PC_ZERO = '0;
  localparam logic [PC_W-1:0] PC_MAX  = '1;
  localparam logic [DP_W-1:0] DP_ONE  = DP_W'(1);

  state_t          st;
  logic [PC_W-1:0] depth;

  // RAM addresses follow the pointers directly so a FETCH cycle reads both
  assign pm_addr = pc;
  assign dm_addr = dp;
  assign state   = st;

  // Write port and input request: combinational so the write commits at the
  // edge that ends DECODE / the IN_WAIT accept cycle
  always_comb begin
    dm_we    = 1'b0;
    dm_wdata = 8'h00;
    in_req   = (st == S_IN_WAIT);
    case (st)
      S_DECODE: begin
        if (pm_rdata == OP_INC) begin
          dm_we    = 1'b1;
          dm_wdata = dm_rdata + 8'd1;
        end else if (pm_rdata == OP_DEC) begin
          dm_we    = 1'b1;
          dm_wdata = dm_rdata - 8'd1;
        end
      end
      S_IN_WAIT: begin
        if (in_valid) begin
          dm_we    = 1'b1;
          dm_wdata = in_data;
        end
      end
      default: ;
    endcase
  end

  // Main sequencer FSM: pointers, bracket depth, I/O and status registers
  always_ff @(posedge clock) begin
    if (reset) begin
      st        <= S_IDLE;
      pc        <= '0;
      dp        <= '0;
      depth     <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (st)
        S_IDLE, S_HALT, S_ERROR: begin
          if (go) begin
            pc     <= '0;
            dp     <= '0;
            halted <= 1'b0;
            error  <= 1'b0;
            st     <= S_FETCH;
          end
        end

        S_FETCH: st <= S_DECODE;

        S_DECODE: begin
          case (pm_rdata)
            OP_INC, OP_DEC: begin
              pc <= pc + PC_ONE;
              st <= S_FETCH;
            end
            OP_RGT: begin
              dp <= dp + DP_ONE;
              pc <= pc + PC_ONE;
              st <= S_FETCH;
            end
            OP_LFT: begin
              dp <= dp - DP_ONE;
              pc <= pc + PC_ONE;
              st <= S_FETCH;
            end
            OP_OUT: begin
              out_data  <= dm_rdata;
              out_valid <= 1'b1;
              st        <= S_OUT_WAIT;
            end
            OP_IN: st <= S_IN_WAIT;
            OP_OPEN: begin
              pc <= pc + PC_ONE;
              if (dm_rdata == 8'h00) begin
                depth <= PC_ONE;
                st    <= S_SF_FETCH;
              end else begin
                st <= S_FETCH;
              end
            end
            OP_CLS: begin
              if (dm_rdata != 8'h00) begin
                depth <= PC_ONE;
                pc    <= pc - PC_ONE;
                st    <= S_SB_FETCH;
              end else begin
                pc <= pc + PC_ONE;
                st <= S_FETCH;
              end
            end
            OP_END: begin
              halted <= 1'b1;
              st     <= S_HALT;
            end
            default: begin
              pc <= pc + PC_ONE;
              st <= S_FETCH;
            end
          endcase
        end

        S_OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pc        <= pc + PC_ONE;
            st        <= S_FETCH;
          end
        end

        S_IN_WAIT: begin
          if (in_valid) begin
            pc <= pc + PC_ONE;
            st <= S_FETCH;
          end
        end

        S_SF_FETCH: st <= S_SF_CHECK;

        // Forward scan: a ']' at depth 1 is the match; running into program
        // end (0x00) or the top of program memory means no match exists
        S_SF_CHECK: begin
          if (pm_rdata == OP_END) begin
            error <= 1'b1;
            st    <= S_ERROR;
          end else if (pm_rdata == OP_CLS && depth == PC_ONE) begin
            pc <= pc + PC_ONE;
            st <= S_FETCH;
          end else if (pc == PC_MAX) begin
            error <= 1'b1;
            st    <= S_ERROR;
          end else begin
            if (pm_rdata == OP_OPEN)     depth <= depth + PC_ONE;
            else if (pm_rdata == OP_CLS) depth <= depth - PC_ONE;
            pc <= pc + PC_ONE;
            st <= S_SF_FETCH;
          end
        end

        S_SB_FETCH: st <= S_SB_CHECK;

        // Backward scan: mirror image, resuming just past the matching '['
        S_SB_CHECK: begin
          if (pm_rdata == OP_END) begin
            error <= 1'b1;
            st    <= S_ERROR;
          end else if (pm_rdata == OP_OPEN && depth == PC_ONE) begin
            pc <= pc + PC_ONE;
            st <= S_FETCH;
          end else if (pc == PC_ZERO) begin
            error <= 1'b1;
            st    <= S_ERROR;
          end else begin
            if (pm_rdata == OP_CLS)       depth <= depth + PC_ONE;
            else if (pm_rdata == OP_OPEN) depth <= depth - PC_ONE;
            pc <= pc - PC_ONE;
            st <= S_SB_FETCH;
          end
        end

        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
